// File: rtl/digital_clock_gen2.sv
// digital_clock_gen2: BCD time-of-day clock driven by a CLK_HZ prescaler.
// Time is kept internally as 24-hour BCD; the 12/24-hour view is purely
// combinational. Optional alarm logic is built when the macro
// DIGITAL_CLOCK_GEN2_ALARM_EN is defined; otherwise the alarm ports are
// present but inert and alarm always reads 0.
module digital_clock_gen2 #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       mode_12h,
    input  logic       set_valid,
    input  logic [1:0] set_hour_tens,
    input  logic [3:0] set_hour_ones,
    input  logic [2:0] set_min_tens,
    input  logic [3:0] set_min_ones,
    input  logic [2:0] set_sec_tens,
    input  logic [3:0] set_sec_ones,
    input  logic       alarm_set,
    input  logic       alarm_en,
    input  logic       alarm_ack,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] hour_tens,
    output logic       pm,
    output logic       tick_1hz,
    output logic       set_err,
    output logic       alarm
);

    localparam logic [31:0] PRESC_MAX = CLK_HZ - 32'd1;

    logic [31:0] presc_q, presc_d;
    logic [1:0]  hour_t_q, hour_t_d;
    logic [3:0]  hour_o_q, hour_o_d;
    logic [2:0]  min_t_q, min_t_d;
    logic [3:0]  min_o_q, min_o_d;
    logic [2:0]  sec_t_q, sec_t_d;
    logic [3:0]  sec_o_q, sec_o_d;
    logic        tick_q, tick_d;
    logic        set_err_q, set_err_d;
    logic        time_load;
    logic        hm_ok;
    logic        set_ok;

    // Hour/minute fields are shared by time set and alarm set, so range them once.
    assign hm_ok  = (set_hour_tens < 2'd2 && set_hour_ones <= 4'd9) ||
                    (set_hour_tens == 2'd2 && set_hour_ones <= 4'd3);
    assign set_ok = hm_ok && set_min_tens <= 3'd5 && set_min_ones <= 4'd9 &&
                    set_sec_tens <= 3'd5 && set_sec_ones <= 4'd9;

`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
    logic [1:0] al_hour_t_q, al_hour_t_d;
    logic [3:0] al_hour_o_q, al_hour_o_d;
    logic [2:0] al_min_t_q, al_min_t_d;
    logic [3:0] al_min_o_q, al_min_o_d;
    logic       alarm_q, alarm_d;
`endif

    // Next-state: set has priority, then prescaler advance with BCD carry chain.
    always_comb begin
        presc_d   = presc_q;
        hour_t_d  = hour_t_q;
        hour_o_d  = hour_o_q;
        min_t_d   = min_t_q;
        min_o_d   = min_o_q;
        sec_t_d   = sec_t_q;
        sec_o_d   = sec_o_q;
        tick_d    = 1'b0;
        set_err_d = 1'b0;
        time_load = 1'b0;
        if (set_valid) begin
            // A rejected set freezes everything for that edge, including the prescaler.
            if (set_ok) begin
                hour_t_d  = set_hour_tens;
                hour_o_d  = set_hour_ones;
                min_t_d   = set_min_tens;
                min_o_d   = set_min_ones;
                sec_t_d   = set_sec_tens;
                sec_o_d   = set_sec_ones;
                presc_d   = 32'd0;
                time_load = 1'b1;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (!hold) begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = 32'd0;
                tick_d    = 1'b1;
                time_load = 1'b1;
                if (sec_o_q != 4'd9) begin
                    sec_o_d = sec_o_q + 4'd1;
                end else begin
                    sec_o_d = 4'd0;
                    if (sec_t_q != 3'd5) begin
                        sec_t_d = sec_t_q + 3'd1;
                    end else begin
                        sec_t_d = 3'd0;
                        if (min_o_q != 4'd9) begin
                            min_o_d = min_o_q + 4'd1;
                        end else begin
                            min_o_d = 4'd0;
                            if (min_t_q != 3'd5) begin
                                min_t_d = min_t_q + 3'd1;
                            end else begin
                                min_t_d = 3'd0;
                                if (hour_t_q == 2'd2 && hour_o_q == 4'd3) begin
                                    hour_t_d = 2'd0;
                                    hour_o_d = 4'd0;
                                end else if (hour_o_q == 4'd9) begin
                                    hour_o_d = 4'd0;
                                    hour_t_d = hour_t_q + 2'd1;
                                end else begin
                                    hour_o_d = hour_o_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end

`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
        al_hour_t_d = al_hour_t_q;
        al_hour_o_d = al_hour_o_q;
        al_min_t_d  = al_min_t_q;
        al_min_o_d  = al_min_o_q;
        alarm_d     = alarm_q;
        if (alarm_set && !set_valid) begin
            if (hm_ok && set_min_tens <= 3'd5 && set_min_ones <= 4'd9) begin
                al_hour_t_d = set_hour_tens;
                al_hour_o_d = set_hour_ones;
                al_min_t_d  = set_min_tens;
                al_min_o_d  = set_min_ones;
            end else begin
                set_err_d = 1'b1;
            end
        end
        if (time_load && alarm_en &&
            {hour_t_d, hour_o_d, min_t_d, min_o_d, sec_t_d, sec_o_d} ==
            {al_hour_t_q, al_hour_o_q, al_min_t_q, al_min_o_q, 3'd0, 4'd0}) begin
            alarm_d = 1'b1;
        end
        // Acknowledge or disarm overrides a match on the same edge.
        if (alarm_ack || !alarm_en) begin
            alarm_d = 1'b0;
        end
`endif
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q     <= 32'd0;
            hour_t_q    <= 2'd0;
            hour_o_q    <= 4'd0;
            min_t_q     <= 3'd0;
            min_o_q     <= 4'd0;
            sec_t_q     <= 3'd0;
            sec_o_q     <= 4'd0;
            tick_q      <= 1'b0;
            set_err_q   <= 1'b0;
`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
            al_hour_t_q <= 2'd0;
            al_hour_o_q <= 4'd0;
            al_min_t_q  <= 3'd0;
            al_min_o_q  <= 4'd0;
            alarm_q     <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            hour_t_q    <= hour_t_d;
            hour_o_q    <= hour_o_d;
            min_t_q     <= min_t_d;
            min_o_q     <= min_o_d;
            sec_t_q     <= sec_t_d;
            sec_o_q     <= sec_o_d;
            tick_q      <= tick_d;
            set_err_q   <= set_err_d;
`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
            al_hour_t_q <= al_hour_t_d;
            al_hour_o_q <= al_hour_o_d;
            al_min_t_q  <= al_min_t_d;
            al_min_o_q  <= al_min_o_d;
            alarm_q     <= alarm_d;
`endif
        end
    end

`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
    assign alarm = alarm_q;
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = &{1'b0, alarm_set, alarm_en, alarm_ack};
    assign alarm = 1'b0;
`endif

    logic [4:0] hour_bin;
    logic [4:0] disp_h;

    // Display view: 12-hour mapping is applied to the binary hour, then re-split to BCD.
    always_comb begin
        hour_bin = {3'd0, hour_t_q} * 5'd10 + {1'b0, hour_o_q};
        disp_h   = hour_bin;
        if (mode_12h) begin
            if (hour_bin == 5'd0) begin
                disp_h = 5'd12;
            end else if (hour_bin > 5'd12) begin
                disp_h = hour_bin - 5'd12;
            end
        end
        // Low-nibble subtraction is exact here: 20 mod 16 = 4, and results stay below 10.
        if (disp_h >= 5'd20) begin
            hour_tens = 4'd2;
            hour_ones = disp_h[3:0] - 4'd4;
        end else if (disp_h >= 5'd10) begin
            hour_tens = 4'd1;
            hour_ones = disp_h[3:0] - 4'd10;
        end else begin
            hour_tens = 4'd0;
            hour_ones = disp_h[3:0];
        end
    end

    assign pm       = (hour_bin >= 5'd12);
    assign min_tens = {1'b0, min_t_q};
    assign min_ones = min_o_q;
    assign sec_tens = {1'b0, sec_t_q};
    assign sec_ones = sec_o_q;
    assign tick_1hz = tick_q;
    assign set_err  = set_err_q;

endmodule

// File: tb/tb_digital_clock_gen2.sv
// Directed bench for digital_clock_gen2 at CLK_HZ=4.
module tb_digital_clock_gen2;

    localparam int CLK_HZ = 4;
`ifdef DIGITAL_CLOCK_GEN2_ALARM_EN
    localparam logic ALARM_BUILD = 1'b1;
`else
    localparam logic ALARM_BUILD = 1'b0;
`endif

    logic       clk, reset, hold, mode_12h, set_valid;
    logic [1:0] set_hour_tens;
    logic [3:0] set_hour_ones;
    logic [2:0] set_min_tens;
    logic [3:0] set_min_ones;
    logic [2:0] set_sec_tens;
    logic [3:0] set_sec_ones;
    logic       alarm_set, alarm_en, alarm_ack;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
    logic       pm, tick_1hz, set_err, alarm;

    int checks = 0;
    int failures = 0;

    digital_clock_gen2 #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .reset(reset), .hold(hold), .mode_12h(mode_12h),
        .set_valid(set_valid),
        .set_hour_tens(set_hour_tens), .set_hour_ones(set_hour_ones),
        .set_min_tens(set_min_tens), .set_min_ones(set_min_ones),
        .set_sec_tens(set_sec_tens), .set_sec_ones(set_sec_ones),
        .alarm_set(alarm_set), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
        .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
        .pm(pm), .tick_1hz(tick_1hz), .set_err(set_err), .alarm(alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [23:0] set_v;
        logic        mode;
        logic [23:0] exp_disp;
        logic        exp_pm;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [23:0] disp();
        return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input logic [23:0] v);
        set_hour_tens = v[21:20];
        set_hour_ones = v[19:16];
        set_min_tens  = v[14:12];
        set_min_ones  = v[11:8];
        set_sec_tens  = v[6:4];
        set_sec_ones  = v[3:0];
    endtask

    task automatic do_set(input logic [23:0] v);
        drive_fields(v);
        set_valid = 1'b1;
        step();
        set_valid = 1'b0;
    endtask

    initial begin
        int ticks;
        int first_tick;

        vecs[0]  = '{24'h000000, 1'b1, 24'h120000, 1'b0, 1'b0};
        vecs[1]  = '{24'h123456, 1'b1, 24'h123456, 1'b1, 1'b0};
        vecs[2]  = '{24'h130509, 1'b1, 24'h010509, 1'b1, 1'b0};
        vecs[3]  = '{24'h130509, 1'b0, 24'h130509, 1'b1, 1'b0};
        vecs[4]  = '{24'h235959, 1'b1, 24'h115959, 1'b1, 1'b0};
        vecs[5]  = '{24'h240000, 1'b0, 24'h235959, 1'b1, 1'b1};
        vecs[6]  = '{24'h106000, 1'b0, 24'h235959, 1'b1, 1'b1};
        vecs[7]  = '{24'h010000, 1'b1, 24'h010000, 1'b0, 1'b0};
        vecs[8]  = '{24'h11595A, 1'b1, 24'h010000, 1'b0, 1'b1};
        vecs[9]  = '{24'h090909, 1'b0, 24'h090909, 1'b0, 1'b0};
        vecs[10] = '{24'h290000, 1'b0, 24'h090909, 1'b0, 1'b1};
        vecs[11] = '{24'h110000, 1'b1, 24'h110000, 1'b0, 1'b0};

        reset = 1'b0; hold = 1'b0; mode_12h = 1'b0; set_valid = 1'b0;
        alarm_set = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0;
        drive_fields(24'h000000);

        // Reset state
        #12;
        chk("reset_disp24", disp(), 24'h000000);
        mode_12h = 1'b1;
        #1;
        chk("reset_disp12", disp(), 24'h120000);
        chk("reset_pm", pm, 1'b0);
        chk("reset_tick", tick_1hz, 1'b0);
        chk("reset_err", set_err, 1'b0);
        chk("reset_alarm", alarm, 1'b0);
        mode_12h = 1'b0;

        // Release and run 12 cycles
        @(posedge clk);
        #1;
        reset = 1'b1;
        ticks = 0;
        first_tick = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (tick_1hz) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
        end
        chk("run12_ticks", ticks, 3);
        chk("run12_first_tick", first_tick, 4);
        chk("run12_disp", disp(), 24'h000003);

        // Table: loads under hold, display in both modes, range checking
        hold = 1'b1;
        for (int i = 0; i < 12; i++) begin
            mode_12h = vecs[i].mode;
            do_set(vecs[i].set_v);
            chk($sformatf("vec%0d_disp", i), disp(), vecs[i].exp_disp);
            chk($sformatf("vec%0d_pm", i), pm, vecs[i].exp_pm);
            chk($sformatf("vec%0d_err", i), set_err, vecs[i].exp_err);
        end

        // Rejected set: single set_err pulse, time unchanged
        do_set(24'h110060);
        chk("rej_err_pulse", set_err, 1'b1);
        step();
        chk("rej_err_clear", set_err, 1'b0);
        chk("rej_disp", disp(), 24'h110000);

        // Midnight rollover in both display modes
        hold = 1'b0;
        mode_12h = 1'b0;
        do_set(24'h235958);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 4) begin
                chk("roll_tick1", tick_1hz, 1'b1);
                chk("roll_disp24_a", disp(), 24'h235959);
                mode_12h = 1'b1;
                #1;
                chk("roll_disp12_a", disp(), 24'h115959);
                chk("roll_pm_a", pm, 1'b1);
                mode_12h = 1'b0;
            end
            if (i == 8) begin
                chk("roll_tick2", tick_1hz, 1'b1);
                chk("roll_disp24_b", disp(), 24'h000000);
                mode_12h = 1'b1;
                #1;
                chk("roll_disp12_b", disp(), 24'h120000);
                chk("roll_pm_b", pm, 1'b0);
                mode_12h = 1'b0;
            end
        end

        // Set on the prescaler-wrap cycle
        do_set(24'h000000);
        step(); step(); step();
        do_set(24'h051020);
        chk("wrapset_tick", tick_1hz, 1'b0);
        chk("wrapset_disp", disp(), 24'h051020);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("wrapset_tick_c%0d", i), tick_1hz, (i == 4) ? 1'b1 : 1'b0);
        end
        chk("wrapset_disp_after", disp(), 24'h051021);

        // Hold mid-second
        step(); step();
        hold = 1'b1;
        ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tick_1hz) ticks++;
        end
        chk("hold_ticks", ticks, 0);
        chk("hold_disp", disp(), 24'h051021);
        hold = 1'b0;
        step();
        chk("hold_resume_c1", tick_1hz, 1'b0);
        step();
        chk("hold_resume_c2", tick_1hz, 1'b1);
        chk("hold_resume_disp", disp(), 24'h051022);

        // Reset mid-second discards the partial count
        step(); step();
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_disp", disp(), 24'h000000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) chk("midreset_tick_c3", tick_1hz, 1'b0);
            if (i == 4) chk("midreset_tick_c4", tick_1hz, 1'b1);
        end
        chk("midreset_disp_after", disp(), 24'h000001);

        // Alarm
        alarm_en = 1'b1;
        drive_fields(24'h073000);
        alarm_set = 1'b1;
        step();
        alarm_set = 1'b0;
        chk("alarm_set_err", set_err, 1'b0);
        do_set(24'h072959);
        chk("alarm_pre", alarm, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 3) chk("alarm_c3", alarm, 1'b0);
        end
        chk("alarm_time", disp(), 24'h073000);
        chk("alarm_rise", alarm, ALARM_BUILD);
        step();
        chk("alarm_hold", alarm, ALARM_BUILD);
        alarm_ack = 1'b1;
        step();
        alarm_ack = 1'b0;
        chk("alarm_ack_clear", alarm, 1'b0);
        drive_fields(24'h250000);
        alarm_set = 1'b1;
        step();
        alarm_set = 1'b0;
        chk("alarm_bad_set_err", set_err, ALARM_BUILD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digital_clock_gen2.md
DIGITAL_CLOCK_GEN2 -- requirements
Module: digital_clock_gen2

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock cycles per second; legal range 2..2^32-1.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 hold  input  1  1 = freeze prescaler and time.
REQ-005 mode_12h  input  1  0 = 24-hour display, 1 = 12-hour display.
REQ-006 set_valid  input  1  one-cycle strobe: load time from set_* fields.
REQ-007 set_hour_tens/set_hour_ones/set_min_tens/set_min_ones/set_sec_tens/set_sec_ones  input  2/4/3/4/3/4  BCD load value, always 24-hour.
REQ-008 alarm_set  input  1  one-cycle strobe: load alarm hour/min from set_hour_*/set_min_* fields.
REQ-009 alarm_en  input  1  alarm arm level.
REQ-010 alarm_ack  input  1  clears alarm.
REQ-011 sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens  output  4 each  BCD display digits.
REQ-012 pm  output  1  1 when internal hour is 12..23 (valid in both modes).
REQ-013 tick_1hz  output  1  one-cycle pulse per advanced second.
REQ-014 set_err  output  1  one-cycle pulse on rejected set_valid/alarm_set.
REQ-015 alarm  output  1  alarm ringing.

Function
REQ-016 Prescaler counts 0..CLK_HZ-1 while hold=0; at CLK_HZ-1 it wraps to 0, time advances one second on that edge, and tick_1hz is 1 for the following cycle.
REQ-017 Time is held internally as 24-hour BCD; carries: sec 59->00 increments min, min 59->00 increments hour, 23:59:59 -> 00:00:00.
REQ-018 Display digits are combinational from internal time: mode_12h=0 -> hours 00..23; mode_12h=1 -> internal 00 -> 12, 01..12 unchanged, 13..23 -> 01..11; mode change visible same cycle.
REQ-019 set_valid with every digit in range (hour 00..23, min/sec tens 0..5, ones 0..9) loads time on that edge, clears prescaler to 0, suppresses any coincident tick; set wins over a simultaneous prescaler wrap.
REQ-020 set_valid with any out-of-range digit leaves time and prescaler unchanged and pulses set_err next cycle.
REQ-021 set_valid honoured while hold=1; time stays frozen at the loaded value.
REQ-022 set_valid and alarm_set in the same cycle: set_valid processed, alarm_set ignored.

Reset
REQ-023 reset low asynchronously forces time 00:00:00, prescaler 0, tick_1hz 0, set_err 0, alarm 0, alarm time 00:00; outputs read 00:00:00 (mode_12h=1 shows 12:00:00, pm=0).
REQ-024 Release is synchronous to clk; first tick_1hz occurs CLK_HZ cycles after the first edge with reset high, hold low.
REQ-025 Reset mid-second discards the partial prescaler count.

Configuration
REQ-026 Macro DIGITAL_CLOCK_GEN2_ALARM_EN defined: alarm_set loads alarm hour/min (same range check as REQ-019, err via set_err); alarm rises on the edge where time advances or is set to alarm HH:MM:00 while alarm_en=1; alarm clears on alarm_ack=1 or alarm_en=0; ack wins over coincident match.
REQ-027 Macro undefined: all ports still present, alarm tied 0, alarm_set/alarm_en/alarm_ack ignored, alarm_set never raises set_err.

Verification (CLK_HZ=4)
REQ-028 Reset low then high, run 12 cycles -> tick_1hz pulses 3 times, display 00:00:03.
REQ-029 set_valid 23:59:58, run 8 cycles -> 23:59:59 then 00:00:00; mode_12h=1 shows 11:59:59 pm=1 then 12:00:00 pm=0.
REQ-030 set_valid 24:00:00 or sec_tens=6 -> time unchanged, set_err single pulse.
REQ-031 set_valid on the cycle prescaler=3 -> loaded value held, no tick that cycle, next tick 4 cycles later.
REQ-032 hold=1 for 10 cycles mid-second -> no tick, time and prescaler frozen, resume with remaining count.
REQ-033 Alarm build: alarm_set 07:30, set_valid 07:29:59, alarm_en=1 -> alarm rises at 07:30:00, clears on alarm_ack; non-alarm build -> alarm stays 0.
